// File: rtl/uart_tx_param.sv
// ---------------------------------------------------------------------------
// uart_tx_param
//   Buffered, parameterised UART transmitter. Bytes written through a small
//   FIFO are serialised as: start bit, DATA_BITS data bits (MSB or LSB first),
//   optional even/odd parity bit, one or two stop bits. Every bit lasts
//   CLKS_PER_BIT clock cycles. Queued frames are sent back-to-back.
//
// Parameters
//   DATA_BITS     payload bits per frame (5..9)
//   CLKS_PER_BIT  clock cycles per serial bit (2..255)
//   FIFO_DEPTH    transmit buffer entries, power of two (2..16)
//   MSB_FIRST     1 = MSB sent first, 0 = LSB sent first
//
// Ports
//   clk_3125     in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   parity_mode  in   00 none, 01 even, 10 odd, 11 none (latched per frame)
//   two_stop     in   1 = two stop bits (latched per frame)
//   wr_en        in   FIFO write strobe, ignored while full
//   wr_data      in   payload to queue
//   full         out  FIFO holds FIFO_DEPTH entries
//   tx           out  registered serial line, idle high
//   busy         out  high from first start-bit cycle to last stop-bit cycle
//   tx_done      out  high for the final cycle of each frame's last stop bit
// ---------------------------------------------------------------------------
module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 27,
    parameter int FIFO_DEPTH   = 4,
    parameter int MSB_FIRST    = 1
) (
    input  logic                 clk_3125,
    input  logic                 rst_n,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 full,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] PRE_CNT  = 8'(CLKS_PER_BIT - 2);
    localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic [DATA_BITS-1:0] w_head;

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = wr_en && !full;
    assign w_head  = r_mem[r_rd_ptr];

    // NOTE: storage is not reset; the count alone defines which entries are valid.
    always_ff @(posedge clk_3125) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [7:0]           r_clk_cnt;
    logic [3:0]           r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_par_en;
    logic                 r_par_odd;
    logic                 r_two_stop;
    logic                 r_parity;

    logic                 w_bit_end;
    logic                 w_last_stop;
    logic                 w_frame_end;
    logic                 w_cur_bit;
    logic                 w_next_bit;
    logic [DATA_BITS-1:0] w_shifted;

    assign w_bit_end   = (r_clk_cnt == LAST_CNT);
    assign w_last_stop = !r_two_stop || r_stop_idx;
    assign w_frame_end = (r_state == S_STOP) && w_bit_end && w_last_stop;
    // Pop either from idle or exactly at the end of a frame, so queued
    // frames follow with no idle cycle in between.
    assign w_pop       = !w_empty && ((r_state == S_IDLE) || w_frame_end);

    assign w_cur_bit  = (MSB_FIRST != 0) ? r_shift[DATA_BITS-1] : r_shift[0];
    assign w_next_bit = (MSB_FIRST != 0) ? r_shift[DATA_BITS-2] : r_shift[1];
    assign w_shifted  = (MSB_FIRST != 0) ? {r_shift[DATA_BITS-2:0], 1'b0}
                                         : {1'b0, r_shift[DATA_BITS-1:1]};

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_two_stop <= 1'b0;
            r_parity   <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            // NOTE: tx_done defaults low every cycle so it can only ever be a single-cycle pulse.
            tx_done <= 1'b0;
            // Registered output: raise it on the edge that enters the last cycle.
            if (r_state == S_STOP && w_last_stop && r_clk_cnt == PRE_CNT) begin
                tx_done <= 1'b1;
            end

            if (w_pop) begin
                // Frame settings are captured here and held for the whole frame.
                r_shift    <= w_head;
                r_parity   <= ^w_head;
                r_par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                r_par_odd  <= (parity_mode == 2'b10);
                r_two_stop <= two_stop;
                r_state    <= S_START;
                r_clk_cnt  <= '0;
                r_bit_idx  <= '0;
                r_stop_idx <= 1'b0;
                tx         <= 1'b0;
                busy       <= 1'b1;
            end else if (r_state == S_IDLE) begin
                tx   <= 1'b1;
                busy <= 1'b0;
            end else if (!w_bit_end) begin
                r_clk_cnt <= r_clk_cnt + 8'd1;
            end else begin
                r_clk_cnt <= '0;
                case (r_state)
                    S_START: begin
                        r_state <= S_DATA;
                        tx      <= w_cur_bit;
                    end
                    S_DATA: begin
                        if (r_bit_idx == LAST_IDX) begin
                            if (r_par_en) begin
                                r_state <= S_PARITY;
                                tx      <= r_parity ^ r_par_odd;
                            end else begin
                                r_state <= S_STOP;
                                tx      <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                            r_shift   <= w_shifted;
                            tx        <= w_next_bit;
                        end
                    end
                    S_PARITY: begin
                        r_state <= S_STOP;
                        tx      <= 1'b1;
                    end
                    S_STOP: begin
                        if (!w_last_stop) begin
                            r_stop_idx <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            tx      <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        tx      <= 1'b1;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_param
//   Two instances: A uses the default parameters, B is a 7-bit, LSB-first,
//   depth-2, 4-clocks-per-bit variant. Expected line waveforms come from a
//   frame model that lists the bits of each frame and stretches every bit to
//   CLKS_PER_BIT cycles; queued frames are simply concatenated.
// ---------------------------------------------------------------------------
module tb_uart_tx_param;

    localparam int CPB_A = 27;
    localparam int DB_A  = 8;
    localparam int CPB_B = 4;
    localparam int DB_B  = 7;

    typedef struct packed {
        logic [8:0] data;
        logic [1:0] pm;
        logic       two;
    } frame_t;

    typedef struct {
        int         sel;
        logic [8:0] data;
        logic [1:0] pm;
        logic       two;
        int         exp_bits;
        int         exp_word;
    } vec_t;

    logic       clk_3125    = 1'b0;
    logic       rst_n       = 1'b0;
    logic [1:0] parity_mode = 2'b00;
    logic       two_stop    = 1'b0;
    logic       wr_en_a     = 1'b0;
    logic [7:0] wr_data_a   = '0;
    logic       wr_en_b     = 1'b0;
    logic [6:0] wr_data_b   = '0;
    logic       full_a, tx_a, busy_a, done_a;
    logic       full_b, tx_b, busy_b, done_b;

    uart_tx_param u_dut_a (
        .clk_3125    (clk_3125),
        .rst_n       (rst_n),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .wr_en       (wr_en_a),
        .wr_data     (wr_data_a),
        .full        (full_a),
        .tx          (tx_a),
        .busy        (busy_a),
        .tx_done     (done_a)
    );

    uart_tx_param #(
        .DATA_BITS    (DB_B),
        .CLKS_PER_BIT (CPB_B),
        .FIFO_DEPTH   (2),
        .MSB_FIRST    (0)
    ) u_dut_b (
        .clk_3125    (clk_3125),
        .rst_n       (rst_n),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .wr_en       (wr_en_b),
        .wr_data     (wr_data_b),
        .full        (full_b),
        .tx          (tx_b),
        .busy        (busy_b),
        .tx_done     (done_b)
    );

    always #5 clk_3125 = ~clk_3125;

    int     n_checks = 0;
    int     n_errors = 0;
    bit     m_bits[$];
    frame_t frq[$];
    int     last_len;
    int     last_word;
    vec_t   vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_3125);
        #1;
    endtask

    task automatic sample(input int sel, output logic t, output logic b, output logic d, output logic f);
        if (sel == 0) {t, b, d, f} = {tx_a, busy_a, done_a, full_a};
        else          {t, b, d, f} = {tx_b, busy_b, done_b, full_b};
    endtask

    task automatic drive_wr(input int sel, input logic en, input logic [8:0] data);
        if (sel == 0) begin
            wr_en_a   = en;
            wr_data_a = data[7:0];
        end else begin
            wr_en_b   = en;
            wr_data_b = data[6:0];
        end
    endtask

    // Line-level frame model: the list of bit values in transmission order.
    function automatic void model_frame(input frame_t fr, input int db, input bit msb);
        int ones;
        int idx;
        ones = 0;
        m_bits.delete();
        m_bits.push_back(1'b0);
        for (int k = 0; k < db; k++) begin
            idx = msb ? (db - 1 - k) : k;
            m_bits.push_back(fr.data[idx]);
            ones += int'(fr.data[idx]);
        end
        if (fr.pm == 2'b01)      m_bits.push_back(bit'(ones % 2));
        else if (fr.pm == 2'b10) m_bits.push_back(bit'((ones % 2) == 0));
        m_bits.push_back(1'b1);
        if (fr.two) m_bits.push_back(1'b1);
    endfunction

    // Called in the first start-bit cycle; consumes every frame in frq.
    task automatic run_frames(input int sel);
        int     cpb, db, flen, tx_err, busy_low, done_cnt, done_pos, word, fno;
        bit     msb;
        frame_t fr;
        logic   t, b, d, f;
        cpb = (sel == 0) ? CPB_A : CPB_B;
        db  = (sel == 0) ? DB_A : DB_B;
        msb = (sel == 0);
        fno = 0;
        while (frq.size() > 0) begin
            fr = frq.pop_front();
            model_frame(fr, db, msb);
            flen     = m_bits.size() * cpb;
            tx_err   = 0;
            busy_low = 0;
            done_cnt = 0;
            done_pos = 0;
            word     = 0;
            for (int i = 0; i < flen; i++) begin
                sample(sel, t, b, d, f);
                if (t !== m_bits[i / cpb]) tx_err++;
                if (b !== 1'b1) busy_low++;
                if (d === 1'b1) begin
                    done_cnt++;
                    done_pos = i + 1;
                end else if (d !== 1'b0) begin
                    done_cnt += 100;
                end
                if ((i % cpb) == (cpb / 2) && t === 1'b1) word |= (1 << (i / cpb));
                step();
            end
            check($sformatf("dut%0d f%0d tx_waveform_errs", sel, fno), tx_err, 0);
            check($sformatf("dut%0d f%0d busy_low_cycles", sel, fno), busy_low, 0);
            check($sformatf("dut%0d f%0d tx_done_count", sel, fno), done_cnt, 1);
            check($sformatf("dut%0d f%0d tx_done_pos", sel, fno), done_pos, flen);
            last_len  = done_pos;
            last_word = word;
            fno++;
        end
        sample(sel, t, b, d, f);
        check($sformatf("dut%0d idle_after {tx,busy,done,full}", sel), {t, b, d, f}, 4'b1000);
    endtask

    // Writes the frames in frq on consecutive cycles and checks the line.
    task automatic do_burst(input int sel, input bit scramble, input bit drop_test);
        frame_t wq[$];
        int     n;
        int     flen0;
        int     db;
        logic   t, b, d, f;
        wq = frq;
        n  = wq.size();
        db = (sel == 0) ? DB_A : DB_B;
        model_frame(wq[0], db, sel == 0);
        flen0 = m_bits.size() * ((sel == 0) ? CPB_A : CPB_B);
        parity_mode = wq[0].pm;
        two_stop    = wq[0].two;
        fork
            begin
                for (int k = 0; k < n; k++) begin
                    drive_wr(sel, 1'b1, wq[k].data);
                    step();
                end
                if (drop_test) begin
                    sample(sel, t, b, d, f);
                    check("full_after_burst", f, 1'b1);
                    drive_wr(sel, 1'b1, 9'h155);
                    step();
                    sample(sel, t, b, d, f);
                    check("full_after_dropped_write", f, 1'b1);
                end
                drive_wr(sel, 1'b0, 9'h000);
            end
            begin
                step();
                step();
                run_frames(sel);
            end
            begin
                if (scramble) begin
                    step();
                    step();
                    for (int c = 0; c < flen0 - 2; c++) begin
                        parity_mode = 2'($urandom);
                        two_stop    = 1'($urandom);
                        step();
                    end
                end
            end
        join
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic   t, b, d, f;
        int     bad;
        frame_t fr;

        // sel, data, parity_mode, two_stop, bits per frame, line word (bit i = i-th bit sent)
        vt[0] = '{0, 9'h0A5, 2'b01, 1'b0, 11, 1354};
        vt[1] = '{0, 9'h03C, 2'b00, 1'b1, 11, 1656};
        vt[2] = '{0, 9'h0FF, 2'b10, 1'b0, 11, 2046};
        vt[3] = '{0, 9'h001, 2'b10, 1'b0, 11, 1280};
        vt[4] = '{0, 9'h000, 2'b01, 1'b1, 12, 3072};
        vt[5] = '{0, 9'h000, 2'b11, 1'b0, 10, 512};
        vt[6] = '{1, 9'h041, 2'b01, 1'b0, 10, 642};

        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        sample(0, t, b, d, f);
        check("reset dut0 {tx,busy,done,full}", {t, b, d, f}, 4'b1000);
        sample(1, t, b, d, f);
        check("reset dut1 {tx,busy,done,full}", {t, b, d, f}, 4'b1000);
        rst_n = 1'b1;
        step();

        // Directed vectors
        for (int r = 0; r < 7; r++) begin
            frq.delete();
            frq.push_back('{vt[r].data, vt[r].pm, vt[r].two});
            do_burst(vt[r].sel, 1'b0, 1'b0);
            check($sformatf("vec%0d frame_cycles", r), last_len,
                  vt[r].exp_bits * ((vt[r].sel == 0) ? CPB_A : CPB_B));
            check($sformatf("vec%0d line_word", r), last_word, vt[r].exp_word);
            step();
        end

        // Five consecutive writes into depth 4, plus a sixth while full
        frq.delete();
        for (int k = 0; k < 5; k++) frq.push_back('{9'($urandom_range(0, 255)), 2'b01, 1'b0});
        do_burst(0, 1'b0, 1'b1);
        step();

        // Randomised bursts on the small instance, settings scrambled mid-frame
        for (int it = 0; it < 20; it++) begin
            int   n;
            logic [1:0] pm;
            logic two;
            n   = $urandom_range(1, 3);
            pm  = 2'($urandom);
            two = 1'($urandom);
            frq.delete();
            for (int k = 0; k < n; k++) frq.push_back('{9'($urandom_range(0, 127)), pm, two});
            do_burst(1, n == 1, 1'b0);
            repeat ($urandom_range(0, 3)) step();
        end

        // Randomised frames on the default instance
        for (int it = 0; it < 4; it++) begin
            int   n;
            logic [1:0] pm;
            logic two;
            n   = $urandom_range(1, 2);
            pm  = 2'($urandom);
            two = 1'($urandom);
            frq.delete();
            for (int k = 0; k < n; k++) frq.push_back('{9'($urandom_range(0, 255)), pm, two});
            do_burst(0, n == 1, 1'b0);
            step();
        end

        // Reset at cycle 100 of a frame with two entries queued
        frq.delete();
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    drive_wr(0, 1'b1, 9'h000);
                    step();
                end
                drive_wr(0, 1'b0, 9'h000);
            end
            begin
                step();
                step();
                repeat (99) step();
                sample(0, t, b, d, f);
                check("pre_reset tx (data bit low)", t, 1'b0);
                #2;
                rst_n = 1'b0;
                #1;
                sample(0, t, b, d, f);
                check("async_reset {tx,busy,done,full}", {t, b, d, f}, 4'b1000);
            end
        join
        step();
        step();
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            sample(0, t, b, d, f);
            if (t !== 1'b1 || b !== 1'b0 || d !== 1'b0) bad++;
            step();
        end
        check("post_reset activity_cycles", bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DATA_BITS, default 8: payload bits per frame, legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 27: clk_3125 cycles per serial bit, legal range 2..255.
REQ-003 Parameter FIFO_DEPTH, default 4: transmit buffer entries, power of two, legal range 2..16.
REQ-004 Parameter MSB_FIRST, default 1: 1 = data MSB sent first, 0 = LSB sent first.
REQ-005 Port clk_3125  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-007 Port parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-008 Port two_stop  input  1  1 = two stop bits, 0 = one stop bit.
REQ-009 Port wr_en  input  1  write strobe into FIFO.
REQ-010 Port wr_data  input  DATA_BITS  byte to queue.
REQ-011 Port full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-012 Port tx  output  1  registered serial line, idle high.
REQ-013 Port busy  output  1  high from start-bit cycle through last stop-bit cycle.
REQ-014 Port tx_done  output  1  one-cycle completion pulse per frame.

Function
REQ-015 FIFO write: wr_en=1 and full=0 stores wr_data at the next edge; wr_en=1 with full=1 SHALL drop the data, even if a pop occurs the same cycle.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP; encoding free.
REQ-017 IDLE: tx=1, busy=0; when the FIFO is non-empty, pop head into a shift register, latch parity_mode and two_stop, go to START, drive tx=0 from the same edge.
REQ-018 First start-bit cycle on tx SHALL be the second rising edge after a write sampled into an empty FIFO while IDLE.
REQ-019 Every bit (start, data, parity, each stop) SHALL hold tx for exactly CLKS_PER_BIT cycles; bit counter wraps to 0 at CLKS_PER_BIT-1.
REQ-020 DATA: DATA_BITS bits, order per MSB_FIRST; then PARITY if latched mode is even/odd, else STOP directly.
REQ-021 Parity bit: even = XOR of data bits; odd = inverted XOR of data bits.
REQ-022 STOP: tx=1 for one or two bit periods per latched two_stop.
REQ-023 tx_done SHALL pulse high for exactly the final cycle of the last stop bit; low at all other times.
REQ-024 Back-to-back: if the FIFO is non-empty at the end of the last stop bit, the next start bit SHALL begin on the following cycle, with no idle gap and busy held high.
REQ-025 Changes to parity_mode/two_stop mid-frame SHALL NOT affect the frame in progress.
REQ-026 Frame length in cycles = CLKS_PER_BIT * (1 + DATA_BITS + parity?1:0 + stop bits).

Reset
REQ-027 rst_n=0 SHALL immediately force tx=1, busy=0, tx_done=0, full=0, state IDLE, FIFO empty, all counters 0, independent of clock.
REQ-028 Reset mid-frame SHALL abort the frame and discard queued data; operation resumes at the first edge after rst_n deasserts.

Verification
REQ-029 Defaults, parity 01, 0xA5 written once -> tx: 0,1,0,1,0,0,1,0,1,0(parity),1; each bit 27 cycles; tx_done pulse at cycle 297 of frame.
REQ-030 Defaults, parity 00, two_stop=1, 0x3C -> 11 bits, 297 cycles, no parity bit, two stop bits high.
REQ-031 Parity 10, 0xFF -> parity bit 1; parity 10, 0x01 -> parity bit 0.
REQ-032 Five writes in consecutive cycles while IDLE (depth 4) -> first pops, four queue; full asserts; five frames sent back-to-back with exactly five tx_done pulses, busy never low between them.
REQ-033 rst_n pulsed low at cycle 100 of a frame with two entries queued -> tx=1 asynchronously, no tx_done, no further frames after release.
REQ-034 MSB_FIRST=0, DATA_BITS=7, 0x41 -> data order 1,0,0,0,0,0,1; frame 10 bits with even parity.
